// File: rtl/tdm_demux_1to16_if.sv
// Bus bundle for the 1-to-16 TDM demultiplexer: serial beat inputs plus frame/status outputs.
interface tdm_demux_1to16_if;
  logic        din;
  logic        vld;
  logic        fsync;
  logic [15:0] Y;
  logic [3:0]  SEL;
  logic        frame_vld;
  logic        locked;
  logic        sync_err;
  logic        par_err;

  modport master (
    output din, vld, fsync,
    input  Y, SEL, frame_vld, locked, sync_err, par_err
  );

  modport slave (
    input  din, vld, fsync,
    output Y, SEL, frame_vld, locked, sync_err, par_err
  );
endinterface

// File: rtl/tdm_demux_1to16.sv
// Serial TDM frame demultiplexer with HUNT/LOCK framing and sync/parity error pulses.
// Define TDM_PARITY_EN to add a 17th even-parity beat per frame.
module tdm_demux_1to16 (
  input logic               clk,
  input logic               rst,
  tdm_demux_1to16_if.slave  bus
);

`ifdef TDM_PARITY_EN
  localparam int unsigned SelW = 5;
  localparam int unsigned ShW  = 16;
  localparam logic [SelW-1:0] LastSlot = 5'd16;
`else
  localparam int unsigned SelW = 4;
  localparam int unsigned ShW  = 15;
  localparam logic [SelW-1:0] LastSlot = 4'd15;
`endif

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [ShW-1:0]    shadow_q, shadow_d;
  logic [15:0]       y_q, y_d;
  logic              frame_vld_q, frame_vld_d;
  logic              sync_err_q, sync_err_d;
  logic              par_err_q, par_err_d;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shadow_d    = shadow_q;
    y_d         = y_q;
    frame_vld_d = 1'b0;
    sync_err_d  = 1'b0;
    par_err_d   = 1'b0;
    if (bus.vld) begin
      unique case (state_q)
        StHunt: begin
          if (bus.fsync) begin
            shadow_d[0] = bus.din;
            sel_d       = SelW'(1);
            state_d     = StLock;
          end
        end
        StLock: begin
          if (bus.fsync) begin
            // Frame start; mid-frame fsync drops the partial frame and resyncs.
            sync_err_d  = (sel_q != '0);
            shadow_d[0] = bus.din;
            sel_d       = SelW'(1);
          end else if (sel_q == '0) begin
            sync_err_d = 1'b1;
            sel_d      = '0;
            state_d    = StHunt;
          end else if (sel_q == LastSlot) begin
            sel_d = '0;
`ifdef TDM_PARITY_EN
            if (bus.din == ^shadow_q) begin
              y_d         = shadow_q;
              frame_vld_d = 1'b1;
            end else begin
              par_err_d = 1'b1;
            end
`else
            y_d         = {bus.din, shadow_q[14:0]};
            frame_vld_d = 1'b1;
`endif
          end else begin
            shadow_d[sel_q[3:0]] = bus.din;
            sel_d                = sel_q + SelW'(1);
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      sel_q       <= '0;
      shadow_q    <= '0;
      y_q         <= '0;
      frame_vld_q <= 1'b0;
      sync_err_q  <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      y_q         <= y_d;
      frame_vld_q <= frame_vld_d;
      sync_err_q  <= sync_err_d;
      par_err_q   <= par_err_d;
    end
  end

  assign bus.Y         = y_q;
  assign bus.SEL       = sel_q[3:0];
  assign bus.locked    = (state_q == StLock);
  assign bus.frame_vld = frame_vld_q;
  assign bus.sync_err  = sync_err_q;
`ifdef TDM_PARITY_EN
  assign bus.par_err   = par_err_q;
`else
  assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1to16.sv
// Self-checking bench for tdm_demux_1to16: directed framing scenarios plus random beats vs a slot model.
module tb_tdm_demux_1to16;

`ifdef TDM_PARITY_EN
  localparam int FrameLen = 17;
`else
  localparam int FrameLen = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  tdm_demux_1to16_if bus ();

  tdm_demux_1to16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: slot = -1 means hunting, else index of the next slot to fill.
  int          m_slot = -1;
  bit          m_bits [17];
  logic [15:0] m_y = '0;
  bit          e_fv, e_se, e_pe;
  int          obs_fv = 0, obs_se = 0, obs_pe = 0;

  function automatic logic [3:0] exp_sel();
    return (m_slot < 0) ? 4'd0 : 4'(m_slot % 16);
  endfunction

  task automatic model_beat(input bit fs, input bit d);
    logic [15:0] w;
    if (m_slot < 0) begin
      if (fs) begin
        m_bits[0] = d;
        m_slot    = 1;
      end
    end else if (fs) begin
      e_se      = (m_slot != 0);
      m_bits[0] = d;
      m_slot    = 1;
    end else if (m_slot == 0) begin
      e_se   = 1'b1;
      m_slot = -1;
    end else begin
      m_bits[m_slot] = d;
      m_slot++;
      if (m_slot == FrameLen) begin
        m_slot = 0;
        for (int i = 0; i < 16; i++) w[i] = m_bits[i];
        if (FrameLen == 17 && int'(m_bits[16]) != ($countones(w) % 2)) begin
          e_pe = 1'b1;
        end else begin
          m_y  = w;
          e_fv = 1'b1;
        end
      end
    end
  endtask

  task automatic beat(input bit v, input bit fs, input bit d);
    @(negedge clk);
    bus.vld   = v;
    bus.fsync = fs;
    bus.din   = d;
    @(posedge clk);
    #1;
    e_fv = 1'b0;
    e_se = 1'b0;
    e_pe = 1'b0;
    if (v) model_beat(fs, d);
    obs_fv += int'(bus.frame_vld);
    obs_se += int'(bus.sync_err);
    obs_pe += int'(bus.par_err);
  endtask

  task automatic send_frame(input logic [15:0] data, input int first, input bit gap,
                            input bit bad_par);
    for (int i = first; i < 16; i++) begin
      beat(1'b1, i == 0, data[i]);
      if (gap) beat(1'b0, 1'($urandom), 1'($urandom));
    end
`ifdef TDM_PARITY_EN
    beat(1'b1, 1'b0, (^data) ^ bad_par);
    if (gap) beat(1'b0, 1'($urandom), 1'($urandom));
`endif
  endtask

  task automatic test_reset();
    bus.vld = 1'b0; bus.fsync = 1'b0; bus.din = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.Y !== 16'h0000) begin bad++; $display("FAIL reset_y got=%h exp=0000", bus.Y); end
    total++; if (bus.SEL !== 4'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", bus.SEL); end
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
    total++;
    if ({bus.frame_vld, bus.sync_err, bus.par_err} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses got=%b exp=000", {bus.frame_vld, bus.sync_err, bus.par_err});
    end
    @(negedge clk);
    rst = 1'b0;
    m_slot = -1; m_y = '0;
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, 1'b0, 1'($urandom));
      total++;
      if ({bus.frame_vld, bus.sync_err, bus.par_err, bus.locked} !== 4'b0000) begin
        bad++; $display("FAIL hunt_idle beat=%0d got=%b exp=0000", i,
                        {bus.frame_vld, bus.sync_err, bus.par_err, bus.locked});
      end
    end
  endtask

  task automatic test_frame();
    int fv0 = obs_fv;
    send_frame(16'hA5C3, 0, 1'b0, 1'b0);
    total++; if (bus.Y !== 16'hA5C3) begin bad++; $display("FAIL frame_y got=%h exp=a5c3", bus.Y); end
    total++; if (obs_fv - fv0 != 1) begin bad++; $display("FAIL frame_pulses got=%0d exp=1", obs_fv - fv0); end
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL frame_locked got=%b exp=1", bus.locked); end
    total++; if (bus.SEL !== 4'd0) begin bad++; $display("FAIL frame_sel got=%0d exp=0", bus.SEL); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] frames [2];
    logic [15:0] seen [$];
    int fv0 = obs_fv;
    frames[0] = 16'h0001;
    frames[1] = 16'h8000;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FrameLen; i++) begin
        beat(1'b1, i == 0, (i < 16) ? frames[f][i] : ^frames[f]);
        if (bus.frame_vld) seen.push_back(bus.Y);
        total++;
        if (bus.SEL !== exp_sel()) begin
          bad++; $display("FAIL b2b_sel frame=%0d slot=%0d got=%0d exp=%0d", f, i, bus.SEL, exp_sel());
        end
        beat(1'b0, 1'($urandom), 1'($urandom));
        total++;
        if (bus.frame_vld !== 1'b0) begin bad++; $display("FAIL b2b_idle_pulse got=1 exp=0"); end
      end
    end
    total++; if (obs_fv - fv0 != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", obs_fv - fv0); end
    total++;
    if (seen.size() != 2 || seen[0] !== 16'h0001 || seen[1] !== 16'h8000) begin
      bad++; $display("FAIL b2b_y got_n=%0d exp 0001 then 8000", seen.size());
    end
  endtask

  task automatic test_resync();
    logic [15:0] old_y = m_y;
    int fv0;
    beat(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) beat(1'b1, 1'b0, 1'($urandom));
    beat(1'b1, 1'b1, 1'b1);
    total++; if (bus.sync_err !== 1'b1) begin bad++; $display("FAIL resync_err got=%b exp=1", bus.sync_err); end
    total++; if (bus.SEL !== 4'd1) begin bad++; $display("FAIL resync_sel got=%0d exp=1", bus.SEL); end
    total++; if (bus.Y !== old_y) begin bad++; $display("FAIL resync_keep_y got=%h exp=%h", bus.Y, old_y); end
    fv0 = obs_fv;
    send_frame(16'hFFFF, 1, 1'b0, 1'b0);
    total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL resync_err_len got=1 exp=0"); end
    total++; if (bus.Y !== 16'hFFFF || obs_fv - fv0 != 1) begin
      bad++; $display("FAIL resync_frame got=%h n=%0d exp=ffff n=1", bus.Y, obs_fv - fv0);
    end
  endtask

  task automatic test_unlock();
    logic [15:0] d = 16'($urandom);
    beat(1'b1, 1'b0, 1'b1);
    total++;
    if ({bus.sync_err, bus.locked, bus.SEL} !== {1'b1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL unlock got err=%b lock=%b sel=%0d exp err=1 lock=0 sel=0",
                      bus.sync_err, bus.locked, bus.SEL);
    end
    send_frame(d, 0, 1'b1, 1'b0);
    total++;
    if (bus.Y !== d || bus.locked !== 1'b1) begin
      bad++; $display("FAIL relock got y=%h lock=%b exp y=%h lock=1", bus.Y, bus.locked, d);
    end
  endtask

`ifdef TDM_PARITY_EN
  task automatic test_parity();
    logic [15:0] old_y = m_y;
    int fv0 = obs_fv;
    int pe0 = obs_pe;
    send_frame(16'h0003, 0, 1'b0, 1'b1);
    total++; if (obs_pe - pe0 != 1 || obs_fv != fv0) begin
      bad++; $display("FAIL parity_pulse got pe=%0d fv=%0d exp pe=1 fv=0", obs_pe - pe0, obs_fv - fv0);
    end
    total++; if (bus.Y !== old_y || bus.locked !== 1'b1) begin
      bad++; $display("FAIL parity_keep got y=%h lock=%b exp y=%h lock=1", bus.Y, bus.locked, old_y);
    end
  endtask
`endif

  task automatic test_mid_reset();
    logic [15:0] d = 16'($urandom);
    int fv0 = obs_fv;
    beat(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 9; i++) beat(1'b1, 1'b0, 1'($urandom));
    @(negedge clk);
    bus.vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_slot = -1; m_y = '0;
    total++;
    if ({bus.Y, bus.SEL, bus.locked, bus.frame_vld} !== 22'd0) begin
      bad++; $display("FAIL mid_reset got y=%h sel=%0d lock=%b fv=%b exp all 0",
                      bus.Y, bus.SEL, bus.locked, bus.frame_vld);
    end
    @(negedge clk);
    rst = 1'b0;
    total++; if (obs_fv != fv0) begin bad++; $display("FAIL mid_reset_pulse got=%0d exp=0", obs_fv - fv0); end
    send_frame(d, 0, 1'b0, 1'b0);
    total++; if (bus.Y !== d) begin bad++; $display("FAIL post_reset_frame got=%h exp=%h", bus.Y, d); end
  endtask

  task automatic test_random();
    bit v, fs;
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom % 4) != 0;
      fs = (m_slot == 0) ? (($urandom % 8) != 0) : (($urandom % 24) == 0);
      beat(v, fs, 1'($urandom));
      total++;
      if ({bus.frame_vld, bus.sync_err, bus.par_err} !== {e_fv, e_se, e_pe}) begin
        bad++; $display("FAIL rand_pulses n=%0d got=%b exp=%b", n,
                        {bus.frame_vld, bus.sync_err, bus.par_err}, {e_fv, e_se, e_pe});
      end
      total++;
      if (bus.Y !== m_y || bus.SEL !== exp_sel() || bus.locked !== (m_slot >= 0)) begin
        bad++; $display("FAIL rand_state n=%0d got y=%h sel=%0d lock=%b exp y=%h sel=%0d lock=%b", n,
                        bus.Y, bus.SEL, bus.locked, m_y, exp_sel(), m_slot >= 0);
      end
      total++;
      if (bus.frame_vld && bus.sync_err) begin bad++; $display("FAIL rand_excl n=%0d got both=1", n); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_resync();
    test_unlock();
`ifdef TDM_PARITY_EN
    test_parity();
`endif
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to16.md
TDM_DEMUX_1TO16 -- requirements
Module: tdm_demux_1to16

Interface
REQ-001 The module SHALL have a clk input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have a rst input, 1 bit, reset that is asynchronous and active-high.
REQ-003 The module SHALL have a din input, 1 bit, the serial TDM data bit for the current slot.
REQ-004 The module SHALL have a vld input, 1 bit; a beat is accepted only on a clk edge with vld=1.
REQ-005 The module SHALL have a fsync input, 1 bit, qualified by vld; when 1 it marks the current beat as slot 0.
REQ-006 The module SHALL have a Y output, 16 bits, the last complete frame, with Y[i] equal to the slot-i bit.
REQ-007 The module SHALL have a SEL output, 4 bits, the slot index the next accepted beat will fill.
REQ-008 The module SHALL have a frame_vld output, 1 bit, a one-cycle pulse when Y is updated.
REQ-009 The module SHALL have a locked output, 1 bit, which is 1 while the state is LOCK.
REQ-010 The module SHALL have a sync_err output, 1 bit, a one-cycle pulse on a framing violation.
REQ-011 The module SHALL have a par_err output, 1 bit, a one-cycle pulse on a parity failure; tied 0 when TDM_PARITY_EN is undefined.

Function
REQ-012 The module SHALL implement the two states HUNT and LOCK.
REQ-013 In HUNT, beats with fsync=0 SHALL be discarded; SEL=0, no pulses.
REQ-014 In HUNT, a beat with fsync=1 SHALL store din in shadow[0], set SEL=1 and go to LOCK.
REQ-015 In LOCK, a beat with fsync=0 at SEL=k (k!=0) SHALL store din in shadow[k] and set SEL=k+1.
REQ-016 Data frame completion: a beat at SEL=15 SHALL update Y to {din, shadow[14:0]} on that edge, wrap SEL to 0 and raise frame_vld for the following cycle only; this gives a latency of one edge from the last data beat.
REQ-017 In LOCK, fsync=1 at SEL!=0 SHALL discard the partial frame, pulse sync_err, store din in shadow[0], set SEL=1 and stay in LOCK (resync).
REQ-018 In LOCK, fsync=0 at SEL=0 SHALL pulse sync_err, discard the beat and go to HUNT with SEL=0.
REQ-019 In LOCK, fsync=1 at SEL=0 SHALL be the normal frame start, behaving as REQ-014 with no error.
REQ-020 A cycle with vld=0 SHALL leave all state unchanged, and frame_vld, sync_err and par_err SHALL be 0.
REQ-021 Y SHALL hold its value between frame_vld pulses; partial or errored frames SHALL never reach Y.
REQ-022 frame_vld and sync_err SHALL never both be 1 in the same cycle.

Reset
REQ-023 rst=1 SHALL immediately force the state to HUNT, with SEL=0, Y=16'h0000, shadow=0, and frame_vld, sync_err, par_err and locked all 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, the first accepted fsync=1 beat SHALL start a new frame.

Configuration
REQ-025 TDM_PARITY_EN defined: the frame SHALL be 17 beats, and the slot after slot 15 (SEL=16, so SEL widens internally to 5 bits and the SEL port shows its low 4 bits) SHALL carry even parity of the 16 data bits.
REQ-026 TDM_PARITY_EN defined: Y update and frame_vld SHALL occur on the parity beat.
  - On parity mismatch, Y SHALL be unchanged, par_err SHALL pulse instead of frame_vld, and the state SHALL stay LOCK.
  - fsync rules of REQ-017 and REQ-018 SHALL apply to the parity beat as a non-zero slot.
REQ-027 TDM_PARITY_EN undefined: the frame SHALL be 16 beats per REQ-016 and par_err SHALL be constant 0.

Verification
REQ-028 The bench SHALL check this case: rst pulse, then Y=0, SEL=0, locked=0; 20 beats with fsync=0 -> no pulses, locked stays 0.
REQ-029 The bench SHALL check this case: frame of 16'hA5C3 (bit i in slot i, fsync on slot 0, plus parity 0 if enabled) -> Y=16'hA5C3, exactly one frame_vld pulse, locked=1.
REQ-030 The bench SHALL check this case: two back-to-back frames 16'h0001 then 16'h8000 with vld toggling 1/0 each cycle -> Y=16'h0001 then 16'h8000, two pulses, SEL wraps 15->0.
REQ-031 The bench SHALL check this case: fsync=1 at slot 7 -> sync_err one cycle, SEL=1, old Y kept; the next full frame 16'hFFFF is delivered correctly.
REQ-032 The bench SHALL check this case: after a frame, slot-0 beat with fsync=0 -> sync_err, locked=0, SEL=0; the next fsync beat relocks.
REQ-033 The bench SHALL check this case: with parity enabled, frame 16'h0003 with parity bit 1 -> par_err pulse, Y unchanged. Without parity, also check: rst asserted at slot 9 -> no pulse, Y=0.
